parser_input_arbiter: RTL
=========================

# parser_input_arbiter

Packet-level arbiter sharing the single receive interface of the sequence parser among `N_SRC` upstream sources. It grants one source at a time and holds the grant for a whole packet, from the header word through the beat marked last. It forwards words unchanged onto the parser's `dataIn`/`dataIn_val`/`dataIn_ready`/`dataIN_last` interface. Packets longer than the parser's buffer are truncated at the arbiter and the source is drained, so the parser never sees an oversize packet.

## Interface
- `N_SRC`, default 4: number of requesting sources, 2..16.
- `MAX_WORDS`, default 12: maximum beats per packet, counting header + sequence + 10 data words.
- `clk`, input, 1: single clock, rising edge.
- `reset_b`, input, 1: reset, synchronous, active-low.
- `src_data`, input, 32*N_SRC: source words; source i occupies bits [32i+31:32i].
- `src_val`, input, N_SRC: per-source word valid.
- `src_last`, input, N_SRC: per-source last-beat marker.
- `src_ready`, output, N_SRC: per-source ready. At most one bit is high.
- `dataIn`, output, 32: word to the parser.
- `dataIn_val`, output, 1: valid to the parser.
- `dataIN_last`, output, 1: last marker to the parser.
- `dataIn_ready`, input, 1: ready from the parser.
- `grant`, output, N_SRC: one-hot current owner; 0 when idle.
- `ovf_sticky`, output, N_SRC: per-source oversize flag. Cleared only by reset.

## Operation
- States: `IDLE`, `PASS`, `DRAIN`.
- IDLE:
  - All outputs are quiet: `src_ready`=0, `dataIn_val`=0, `grant`=0.
  - If any `src_val` is high, the winner is chosen by the pick rule. The arbiter registers `grant`, clears the beat counter and moves to PASS.
- PASS, with owner g:
  - `dataIn`=`src_data[g]`, `dataIn_val`=`src_val[g]`, `src_ready[g]`=`dataIn_ready`. All other `src_ready` bits are 0.
  - `dataIN_last` = `src_last[g]` OR (counter == MAX_WORDS-1).
  - A beat is a cycle with `dataIn_val` && `dataIn_ready`. Each beat increments the counter.
  - Beat with `src_last[g]`: go to IDLE and set `rr_ptr` = (g+1) mod N_SRC.
  - Beat at counter == MAX_WORDS-1 with `src_last[g]`=0: this is a truncation. Forward the beat with `dataIN_last` forced to 1, set `ovf_sticky[g]`, and go to DRAIN.
- DRAIN:
  - `dataIn_val`=0 and `src_ready[g]`=1. Words are discarded.
  - On an accepted word with `src_last[g]`: go to IDLE and advance `rr_ptr` as in PASS.
- Pick rule (round robin): the first i with `src_val[i]` set, scanning `rr_ptr`, `rr_ptr`+1, … mod N_SRC.
- Counter is `$clog2(MAX_WORDS)` bits. It never wraps, because it is reset on every grant.
- The arbiter does not inspect packet contents. The header length field is not checked.

## Timing
- Reset values: state IDLE, `rr_ptr`=0, `grant`=0, counter=0, `ovf_sticky`=0, `src_ready`=0, `dataIn_val`=0, `dataIN_last`=0.
- Arbitration takes 1 cycle: a request seen in IDLE in cycle t has `grant` visible in cycle t+1, and its first word can transfer in t+1.
- Datapath in PASS is combinational; no added latency and no buffering.
- There is exactly one idle bubble cycle between consecutive packets, including packets from the same source.
- The parser deasserting `dataIn_ready` (output pending) stalls the owner. The grant is held indefinitely; there is no timeout.
- A source dropping `src_val` mid-packet is a legal stall. The grant is held.
- Requests arriving in the same cycle as a last beat are not considered until the IDLE cycle that follows.
- Reset mid-packet: all state is cleared at the next edge. The parser is reset by the same `reset_b` and drops its partial packet.

## Configuration
- `ARB_STRICT_PRIO_EN` defined: the pick rule becomes lowest-index `src_val` wins. `rr_ptr` is not instantiated and source 0 can starve the others.
- `ARB_STRICT_PRIO_EN` undefined (default): round-robin pick as above.

## Structure
- Shared package `parser_pkg` holds:
  - state enum `arb_state_t` (IDLE/PASS/DRAIN);
  - `WORD_W`=32;
  - `HDR_WORDS`=2;
  - `DATA_WORDS`=10;
  - `MAX_PKT_WORDS` = HDR_WORDS + DATA_WORDS.
  The parser should reference `DATA_WORDS` from the same package.
- One sub-module, `rr_pick`: combinational rotate-and-priority-encode. Inputs are the request vector and pointer; outputs are a one-hot winner and a valid flag. With `ARB_STRICT_PRIO_EN` the pointer is tied to 0.

## Test plan
- **Single packet:** source 1 sends 3 words 0x0009_0005, 0x0000_0001, 0xAABBCC00, with last on the third, parser always ready. Required: `grant`=0b0010 from the cycle after the request, 3 beats forwarded unchanged, `dataIN_last` on beat 3, then `grant`=0.
- **Round robin:** all 4 sources request continuously with 3-word packets. Required: grant order 0,1,2,3,0. With `ARB_STRICT_PRIO_EN` defined, required: source 0 on every grant.
- **Backpressure:** parser holds `dataIn_ready`=0 for 5 cycles mid-packet. Required: `src_ready[g]`=0 during the stall, grant held, no word lost or duplicated.
- **Oversize:** source 2 sends a 15-word packet. Required: 12 beats forwarded with `dataIN_last` forced on beat 12, `ovf_sticky[2]`=1, 3 words drained with `dataIn_val`=0, then IDLE.
- **Mid-packet reset:** `reset_b`=0 for one cycle during beat 4 of a packet. Required: next cycle `grant`=0, `dataIn_val`=0, `rr_ptr`=0, `ovf_sticky`=0.

Source files
------------

// File: rtl/parser_pkg.sv
// parser_pkg
// Shared definitions for the sequence parser and its input arbiter.
// Holds the arbiter state encoding, the word width and the packet sizing
// constants. The parser takes DATA_WORDS from here so that the arbiter's
// truncation limit and the parser's buffer depth always agree.
package parser_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS  = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

  localparam int WORD_W        = 32;
  localparam int HDR_WORDS     = 2;
  localparam int DATA_WORDS    = 10;
  localparam int MAX_PKT_WORDS = HDR_WORDS + DATA_WORDS;

endpackage

// File: rtl/rr_pick.sv
// rr_pick
// Combinational rotate-and-priority-encode. Scans the request vector
// starting at ptr_i and wrapping modulo N_SRC; the first set request wins.
// With a pointer held at 0 this is a plain lowest-index-wins encoder.
//
// Ports:
//   req_i   [N_SRC-1:0]  request vector
//   ptr_i   [PTR_W-1:0]  index scanned first
//   win_o   [N_SRC-1:0]  one-hot winner, 0 when no request
//   valid_o              at least one request present
module rr_pick #(
  parameter int N_SRC = 4,
  parameter int PTR_W = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N_SRC-1:0] win_o,
  output logic             valid_o
);

  int idx;

  // Walk the offsets from the farthest back to the pointer itself so that
  // the closest request to the pointer is the last one written and wins.
  always_comb begin
    win_o   = '0;
    valid_o = |req_i;
    idx     = 0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      idx = (int'(ptr_i) + k) % N_SRC;
      if (req_i[idx]) begin
        win_o = N_SRC'(1) << idx;
      end
    end
  end

endmodule

// File: rtl/parser_input_arbiter.sv
// parser_input_arbiter
// Packet-level arbiter that shares the parser's single receive port among
// N_SRC sources. A grant is held from the header word through the last
// beat. Packets longer than MAX_WORDS are cut: the final forwarded beat is
// marked last, the source's ovf_sticky bit is set and the remainder of the
// packet is accepted from the source and thrown away.
//
// Build option: ARB_STRICT_PRIO_EN selects lowest-index-wins arbitration
// instead of round robin and removes the round-robin pointer.
//
// Ports:
//   clk, reset_b                  clock, synchronous active-low reset
//   src_data [32*N_SRC-1:0]       source words, source i in [32i+31:32i]
//   src_val/src_last [N_SRC-1:0]  per-source valid and last-beat marker
//   src_ready [N_SRC-1:0]         per-source ready, at most one bit high
//   dataIn, dataIn_val,
//   dataIN_last, dataIn_ready     parser receive interface
//   grant [N_SRC-1:0]             one-hot owner, 0 when idle
//   ovf_sticky [N_SRC-1:0]        per-source truncation flag
module parser_input_arbiter
  import parser_pkg::*;
#(
  parameter int N_SRC     = 4,
  parameter int MAX_WORDS = MAX_PKT_WORDS
) (
  input  logic                      clk,
  input  logic                      reset_b,
  input  logic [WORD_W*N_SRC-1:0]   src_data,
  input  logic [N_SRC-1:0]          src_val,
  input  logic [N_SRC-1:0]          src_last,
  output logic [N_SRC-1:0]          src_ready,
  output logic [WORD_W-1:0]         dataIn,
  output logic                      dataIn_val,
  output logic                      dataIN_last,
  input  logic                      dataIn_ready,
  output logic [N_SRC-1:0]          grant,
  output logic [N_SRC-1:0]          ovf_sticky
);

  localparam int PTR_W = $clog2(N_SRC);
  localparam int CNT_W = $clog2(MAX_WORDS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_WORDS - 1);

  arb_state_t         state_q, state_d;
  logic [N_SRC-1:0]   grant_q, grant_d;
  logic [PTR_W-1:0]   own_q, own_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_SRC-1:0]   ovf_q, ovf_d;

  logic [N_SRC-1:0]   pickWin;
  logic               pickValid;
  logic [PTR_W-1:0]   pickIdx;
  logic [PTR_W-1:0]   pickPtr;

  logic               ownVal;
  logic               ownLast;
  logic [WORD_W-1:0]  ownData;
  logic               atLimit;

`ifdef ARB_STRICT_PRIO_EN
  assign pickPtr = '0;
`else
  logic [PTR_W-1:0]   rr_ptr_q;
  logic [PTR_W-1:0]   nextPtr;

  assign nextPtr = (own_q == PTR_W'(N_SRC - 1)) ? '0 : own_q + PTR_W'(1);
  assign pickPtr = rr_ptr_q;
`endif

  rr_pick #(
    .N_SRC (N_SRC),
    .PTR_W (PTR_W)
  ) u_pick (
    .req_i   (src_val),
    .ptr_i   (pickPtr),
    .win_o   (pickWin),
    .valid_o (pickValid)
  );

  // Convert the one-hot winner to an index for the datapath muxes.
  always_comb begin
    pickIdx = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (pickWin[i]) begin
        pickIdx = PTR_W'(i);
      end
    end
  end

  assign ownVal  = src_val[own_q];
  assign ownLast = src_last[own_q];
  assign ownData = src_data[int'(own_q)*WORD_W +: WORD_W];
  assign atLimit = (cnt_q == LAST_CNT);

  assign grant      = grant_q;
  assign ovf_sticky = ovf_q;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    own_d       = own_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    src_ready   = '0;
    dataIn      = '0;
    dataIn_val  = 1'b0;
    dataIN_last = 1'b0;

    case (state_q)
      IDLE: begin
        if (pickValid) begin
          grant_d = pickWin;
          own_d   = pickIdx;
          cnt_d   = '0;
          state_d = PASS;
        end
      end

      PASS: begin
        dataIn           = ownData;
        dataIn_val       = ownVal;
        src_ready[own_q] = dataIn_ready;
        // The limit beat is marked last even if the source has more to send.
        dataIN_last      = ownLast | atLimit;
        if (ownVal && dataIn_ready) begin
          if (ownLast) begin
            grant_d = '0;
            state_d = IDLE;
          end else if (atLimit) begin
            ovf_d[own_q] = 1'b1;
            state_d      = DRAIN;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      DRAIN: begin
        // Keep accepting from the owner so it can finish; nothing reaches the parser.
        src_ready[own_q] = 1'b1;
        if (ownVal && ownLast) begin
          grant_d = '0;
          state_d = IDLE;
        end
      end

      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      state_q <= IDLE;
      grant_q <= '0;
      own_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      own_q   <= own_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

`ifndef ARB_STRICT_PRIO_EN
  // The pointer moves past the owner whenever a packet finishes, whether it
  // ended normally or through a drain.
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      rr_ptr_q <= '0;
    end else if (state_q != IDLE && state_d == IDLE) begin
      rr_ptr_q <= nextPtr;
    end
  end
`endif

endmodule
